// File: rtl/flag_pkg.sv
// Shared encodings for the ALU flag / branch-resolution unit:
// flag bit positions, branch condition codes and carry-op encodings.
package flag_pkg;

  localparam int FLAG_S  = 4;
  localparam int FLAG_Z  = 3;
  localparam int FLAG_CY = 2;
  localparam int FLAG_P  = 1;
  localparam int FLAG_V  = 0;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_NEVER  = 4'h1;
  localparam logic [3:0] COND_Z      = 4'h2;
  localparam logic [3:0] COND_NZ     = 4'h3;
  localparam logic [3:0] COND_CY     = 4'h4;
  localparam logic [3:0] COND_NCY    = 4'h5;
  localparam logic [3:0] COND_S      = 4'h6;
  localparam logic [3:0] COND_NS     = 4'h7;
  localparam logic [3:0] COND_V      = 4'h8;
  localparam logic [3:0] COND_NV     = 4'h9;
  localparam logic [3:0] COND_P      = 4'hA;
  localparam logic [3:0] COND_NP     = 4'hB;
  localparam logic [3:0] COND_LT     = 4'hC;
  localparam logic [3:0] COND_GE     = 4'hD;
  localparam logic [3:0] COND_LE     = 4'hE;
  localparam logic [3:0] COND_GT     = 4'hF;

  localparam logic [1:0] FOP_NONE = 2'b00;
  localparam logic [1:0] FOP_SET  = 2'b01;
  localparam logic [1:0] FOP_CLR  = 2'b10;
  localparam logic [1:0] FOP_CPL  = 2'b11;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: 4-bit condition code against
// the {S,Z,CY,P,V} flag vector.
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic lt_s;

  assign lt_s = flags[FLAG_S] ^ flags[FLAG_V];

  // condition decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      COND_Z:      taken = flags[FLAG_Z];
      COND_NZ:     taken = ~flags[FLAG_Z];
      COND_CY:     taken = flags[FLAG_CY];
      COND_NCY:    taken = ~flags[FLAG_CY];
      COND_S:      taken = flags[FLAG_S];
      COND_NS:     taken = ~flags[FLAG_S];
      COND_V:      taken = flags[FLAG_V];
      COND_NV:     taken = ~flags[FLAG_V];
      COND_P:      taken = flags[FLAG_P];
      COND_NP:     taken = ~flags[FLAG_P];
      COND_LT:     taken = lt_s;
      COND_GE:     taken = ~lt_s;
      COND_LE:     taken = flags[FLAG_Z] | lt_s;
      COND_GT:     taken = ~flags[FLAG_Z] & ~lt_s;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_branch_unit.sv
// Condition-code register, branch resolution and a 2-entry result FIFO
// between the EX-stage flags and fetch/PC-select.
module alu_flag_branch_unit
  import flag_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              sign_in,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              parity_in,
  input  logic              overflow_in,
  input  logic [1:0]        flag_op,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic [4:0]        flags_out,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [4:0]        flags_q, flags_d, flags_in_s, eff_flags_s;
  logic              taken_s, push_s, pop_s;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              slot_taken_q  [2];
  logic [ADDR_W-1:0] slot_target_q [2];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign flags_in_s = {sign_in, zero_in, carry_in, parity_in, overflow_in};

  // flag_op only touches CY and never reaches the bypass path
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = flags_in_s;
    end else begin
      case (flag_op)
        FOP_SET: flags_d[FLAG_CY] = 1'b1;
        FOP_CLR: flags_d[FLAG_CY] = 1'b0;
        FOP_CPL: flags_d[FLAG_CY] = ~flags_q[FLAG_CY];
        default: flags_d = flags_q;
      endcase
    end
  end

  assign eff_flags_s = (BYPASS && flag_we) ? flags_in_s : flags_q;

  cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (eff_flags_s),
    .taken (taken_s)
  );

  assign br_ready  = rst_n && (count_q != 2'd2);
  assign res_valid = (count_q != 2'd0);
  assign push_s    = br_valid && br_ready;
  assign pop_s     = res_valid && res_ready;

  // FIFO pointer/count and saturating counter next state
  always_comb begin
    wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_s  ? ~rd_ptr_q : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push_s && taken_s && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q          <= 5'b00000;
      count_q          <= 2'd0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      cnt_q            <= '0;
      slot_taken_q[0]  <= 1'b0;
      slot_taken_q[1]  <= 1'b0;
      slot_target_q[0] <= '0;
      slot_target_q[1] <= '0;
    end else begin
      flags_q  <= flags_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_s) begin
        slot_taken_q[wr_ptr_q]  <= taken_s;
        slot_target_q[wr_ptr_q] <= br_target;
      end
    end
  end

  assign res_taken  = res_valid ? slot_taken_q[rd_ptr_q]  : 1'b0;
  assign res_target = res_valid ? slot_target_q[rd_ptr_q] : '0;
  assign flags_out  = flags_q;
  assign taken_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Directed self-checking bench for alu_flag_branch_unit (CNT_W=4 so that
// counter saturation is reachable quickly).
module tb_alu_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we, sign_in, zero_in, carry_in, parity_in, overflow_in;
  logic [1:0]  flag_op;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [15:0] br_target;
  logic        br_ready, res_valid, res_ready, res_taken;
  logic [15:0] res_target;
  logic [4:0]  flags_out;
  logic [3:0]  taken_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  alu_flag_branch_unit #(.ADDR_W(16), .CNT_W(4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .sign_in(sign_in),
    .zero_in(zero_in), .carry_in(carry_in), .parity_in(parity_in),
    .overflow_in(overflow_in), .flag_op(flag_op), .br_valid(br_valid),
    .br_cond(br_cond), .br_target(br_target), .br_ready(br_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .flags_out(flags_out), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {sign_in, zero_in, carry_in, parity_in, overflow_in} = f;
  endtask

  task automatic issue(input logic [3:0] c, input logic [15:0] t);
    br_valid = 1'b1; br_cond = c; br_target = t;
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 1'b0; set_flags(5'b00000); flag_op = 2'b00;
    br_valid = 1'b0; br_cond = 4'h0; br_target = 16'h0000; res_ready = 1'b0;
    tick(); tick();
    check_val("rst_br_ready", {31'd0, br_ready}, 32'd0);
    check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_val("rst_flags", {27'd0, flags_out}, 32'd0);
    check_val("rst_cnt", {28'd0, taken_cnt}, 32'd0);
    check_val("rst_target", {16'd0, res_target}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_br_ready", {31'd0, br_ready}, 32'd1);

    // bypass: CY comes in the same cycle as the branch
    tick();
    res_ready = 1'b1; flag_we = 1'b1; set_flags(5'b00111);
    issue(4'h4, 16'h0123);
    tick();
    flag_we = 1'b0; set_flags(5'b00000);
    check_val("byp_valid", {31'd0, res_valid}, 32'd1);
    check_val("byp_taken", {31'd0, res_taken}, 32'd1);
    check_val("byp_target", {16'd0, res_target}, 32'h0123);
    check_val("byp_flags", {27'd0, flags_out}, 32'b00111);
    issue(4'hC, 16'h0200);
    tick();
    check_val("lt_taken", {31'd0, res_taken}, 32'd1);
    check_val("lt_target", {16'd0, res_target}, 32'h0200);
    issue(4'h3, 16'h0300);
    tick();
    check_val("nz_taken", {31'd0, res_taken}, 32'd1);
    issue(4'h2, 16'h0400);
    tick();
    check_val("z_taken", {31'd0, res_taken}, 32'd0);
    check_val("z_target", {16'd0, res_target}, 32'h0400);
    br_valid = 1'b0;
    tick();
    check_val("drain_valid", {31'd0, res_valid}, 32'd0);
    check_val("drain_taken", {31'd0, res_taken}, 32'd0);
    check_val("drain_target", {16'd0, res_target}, 32'd0);
    check_val("cnt_after_byp", {28'd0, taken_cnt}, 32'd3);

    // backpressure: two slots fill, third request is held
    res_ready = 1'b0;
    issue(4'h0, 16'h0010);
    tick();
    check_val("bp_ready1", {31'd0, br_ready}, 32'd1);
    issue(4'h0, 16'h0020);
    tick();
    check_val("bp_full_ready", {31'd0, br_ready}, 32'd0);
    issue(4'h0, 16'h0030);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("bp_hold_target", {16'd0, res_target}, 32'h0010);
      check_val("bp_hold_valid", {31'd0, res_valid}, 32'd1);
    end
    res_ready = 1'b1;
    tick();
    check_val("bp_second", {16'd0, res_target}, 32'h0020);
    tick();
    check_val("bp_third", {16'd0, res_target}, 32'h0030);
    br_valid = 1'b0;
    tick();
    check_val("bp_empty", {31'd0, res_valid}, 32'd0);
    check_val("cnt_after_bp", {28'd0, taken_cnt}, 32'd6);

    // carry ops and flag_we priority
    flag_op = 2'b10;
    tick();
    check_val("fop_clr", {27'd0, flags_out}, 32'b00011);
    flag_op = 2'b11;
    tick();
    check_val("fop_cpl", {27'd0, flags_out}, 32'b00111);
    flag_op = 2'b01; flag_we = 1'b1; set_flags(5'b11000);
    tick();
    check_val("fop_we_prio", {27'd0, flags_out}, 32'b11000);
    flag_op = 2'b00; flag_we = 1'b0; set_flags(5'b00000);
    // registered flags Z=1,S=1,V=0: GT false, LE true
    issue(4'hF, 16'h0050);
    tick();
    check_val("gt_taken", {31'd0, res_taken}, 32'd0);
    issue(4'hE, 16'h0060);
    tick();
    check_val("le_taken", {31'd0, res_taken}, 32'd1);
    br_valid = 1'b0;
    tick();

    // simultaneous push/pop at count 1
    issue(4'h1, 16'h0100);
    tick();
    for (int i = 1; i <= 4; i++) begin
      issue(4'h1, 16'h0100 + 16'(i));
      tick();
      check_val("pp_target", {16'd0, res_target}, 32'h0100 + i - 1 + 1);
      check_val("pp_ready", {31'd0, br_ready}, 32'd1);
    end
    br_valid = 1'b0;
    tick();
    check_val("pp_empty", {31'd0, res_valid}, 32'd0);
    check_val("cnt_after_pp", {28'd0, taken_cnt}, 32'd7);

    // reset mid-operation with two queued entries
    res_ready = 1'b0;
    issue(4'h0, 16'h0AAA);
    tick();
    issue(4'h0, 16'h0BBB);
    tick();
    br_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    check_val("mid_rst_flags", {27'd0, flags_out}, 32'd0);
    check_val("mid_rst_ready", {31'd0, br_ready}, 32'd0);
    check_val("mid_rst_cnt", {28'd0, taken_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_val("mid_rel_ready", {31'd0, br_ready}, 32'd1);
    tick();
    check_val("mid_rel_valid", {31'd0, res_valid}, 32'd0);

    // saturation: 17 taken then 3 not taken
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      issue(4'h0, 16'(i));
      tick();
      if (i == 13) check_val("sat_14", {28'd0, taken_cnt}, 32'd14);
      if (i == 14) check_val("sat_15", {28'd0, taken_cnt}, 32'd15);
    end
    check_val("sat_17", {28'd0, taken_cnt}, 32'd15);
    for (int i = 0; i < 3; i++) begin
      issue(4'h1, 16'h0F00);
      tick();
    end
    check_val("sat_final", {28'd0, taken_cnt}, 32'd15);
    br_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
